// File: rtl/sopc_scope_sys_nios2_qsys_0_oci_dct_ctrl.sv
// Trace-atom packer: collects 2-bit atoms into a 30-bit buffer and emits it
// as one frame when it is full, on flush, or at end of test.
module sopc_scope_sys_nios2_qsys_0_oci_dct_ctrl #(
  parameter int unsigned FULL_COUNT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  output logic        atom_ready,
  input  logic        flush,
  input  logic        test_ending,
  output logic        out_valid,
  output logic [29:0] out_data,
  output logic [3:0]  out_count,
  input  logic        out_ready,
  output logic        test_has_ended,
  output logic [15:0] frame_count
);

  localparam logic [3:0] FULL = 4'(FULL_COUNT);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [29:0] r_buf;
  logic [3:0]  r_cnt;
  logic        r_end;
  logic [15:0] r_frames;

  logic        w_accept, w_end, w_emit_done;
  logic [3:0]  w_cnt_acc;
  logic [29:0] w_buf_acc;

  assign w_accept    = (r_state == S_FILL) && atom_valid;
  assign w_end       = r_end | test_ending;
  assign w_emit_done = (r_state == S_EMIT) && out_ready;
  assign w_cnt_acc   = r_cnt + {3'b000, w_accept};
  // Buffer bits above the fill point are always zero, so OR-ing in the new atom suffices.
  assign w_buf_acc   = w_accept ? (r_buf | ({28'b0, atom_data} << {r_cnt, 1'b0})) : r_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_FILL: begin
        if (w_cnt_acc == FULL)                        w_state_next = S_EMIT;
        else if ((flush || w_end) && w_cnt_acc != '0) w_state_next = S_EMIT;
        else if (w_end)                               w_state_next = S_DONE;
      end
      S_EMIT:  if (out_ready) w_state_next = w_end ? S_DONE : S_FILL;
      default: w_state_next = S_DONE;
    endcase
  end

  always_comb begin
    atom_ready     = (r_state == S_FILL);
    out_valid      = (r_state == S_EMIT);
    test_has_ended = (r_state == S_DONE);
    out_data       = out_valid ? r_buf : '0;
    out_count      = out_valid ? r_cnt : '0;
    frame_count    = r_frames;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf    <= '0;
      r_cnt    <= '0;
      r_end    <= 1'b0;
      r_frames <= '0;
    end else begin
      r_end <= w_end;
      if (w_emit_done) begin
        r_buf <= '0;
        r_cnt <= '0;
        if (r_frames != '1) r_frames <= r_frames + 16'd1;
      end else if (w_accept) begin
        r_buf <= w_buf_acc;
        r_cnt <= w_cnt_acc;
      end
    end
  end

endmodule

// File: tb/tb_sopc_scope_sys_nios2_qsys_0_oci_dct_ctrl.sv
// Scenario bench for the trace-atom packer; expected frames go through a queue.
module tb_sopc_scope_sys_nios2_qsys_0_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush;
  logic        test_ending;
  logic        out_valid;
  logic [29:0] out_data;
  logic [3:0]  out_count;
  logic        out_ready;
  logic        test_has_ended;
  logic [15:0] frame_count;

  typedef struct { logic [29:0] d; logic [3:0] c; } frame_t;
  frame_t sb[$];
  frame_t exp_f;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sopc_scope_sys_nios2_qsys_0_oci_dct_ctrl #(.FULL_COUNT(15)) dut (
    .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom_data(atom_data),
    .atom_ready(atom_ready), .flush(flush), .test_ending(test_ending),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_ready(out_ready), .test_has_ended(test_has_ended), .frame_count(frame_count)
  );

  task automatic do_reset();
    reset = 1'b1; atom_valid = 1'b0; atom_data = '0; flush = 1'b0;
    test_ending = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  task automatic send_atom(input logic [1:0] d);
    atom_valid = 1'b1; atom_data = d;
    @(posedge clk); #1 atom_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pop_exp();
    if (sb.size() > 0) exp_f = sb.pop_front();
    else begin exp_f.d = '1; exp_f.c = '1; end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({atom_ready, out_valid, out_data, out_count, test_has_ended, frame_count} !==
        {1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h c=%0d end=%b fc=%0d, want rdy=1 v=0 d=0 c=0 end=0 fc=0",
               atom_ready, out_valid, out_data, out_count, test_has_ended, frame_count);
    end
  endtask

  task automatic test_full();
    bit ok;
    out_ready = 1'b1;
    sb.push_back('{30'h15555555, 4'd15});
    atom_valid = 1'b1; atom_data = 2'b01;
    repeat (15) @(posedge clk);
    #1 atom_valid = 1'b0;
    wait_valid(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: got no out_valid, want out_valid=1"); end
    pop_exp();
    n_checks++;
    if (out_data !== exp_f.d || out_count !== exp_f.c) begin
      n_fail++;
      $display("FAIL full_frame: got d=%h c=%0d, want d=%h c=%0d", out_data, out_count, exp_f.d, exp_f.c);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || frame_count !== 16'd1 || atom_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_after: got v=%b fc=%0d rdy=%b, want v=0 fc=1 rdy=1", out_valid, frame_count, atom_ready);
    end
  endtask

  task automatic test_flush_hold();
    out_ready = 1'b0;
    send_atom(2'b11);
    send_atom(2'b10);
    sb.push_back('{30'h0000000B, 4'd2});
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || atom_ready !== 1'b0 || out_data !== exp_f.d || out_count !== exp_f.c) begin
      n_fail++;
      $display("FAIL flush_frame: got v=%b rdy=%b d=%h c=%0d, want v=1 rdy=0 d=%h c=%0d",
               out_valid, atom_ready, out_data, out_count, exp_f.d, exp_f.c);
    end
    atom_valid = 1'b1; atom_data = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || atom_ready !== 1'b0 || out_data !== exp_f.d || out_count !== exp_f.c) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got v=%b rdy=%b d=%h c=%0d, want v=1 rdy=0 d=%h c=%0d",
                 i, out_valid, atom_ready, out_data, out_count, exp_f.d, exp_f.c);
      end
    end
    atom_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL hold_release: got v=%b fc=%0d, want v=0 fc=2", out_valid, frame_count);
    end
  endtask

  task automatic test_flush_with_atom();
    out_ready = 1'b1;
    send_atom(2'b10);
    sb.push_back('{30'h00000006, 4'd2});
    atom_valid = 1'b1; atom_data = 2'b01; flush = 1'b1;
    @(posedge clk); #1 begin atom_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_f.d || out_count !== exp_f.c) begin
      n_fail++;
      $display("FAIL flush_atom: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
               out_valid, out_data, out_count, exp_f.d, exp_f.c);
    end
    @(negedge clk);
    n_checks++;
    if (frame_count !== 16'd3) begin
      n_fail++;
      $display("FAIL flush_atom_fc: got %0d, want 3", frame_count);
    end
  endtask

  task automatic test_reset_mid_emit();
    bit ok;
    out_ready = 1'b0;
    send_atom(2'b11);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_emit_pre: got v=%b, want v=1", out_valid); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || frame_count !== 16'd0 || out_data !== 30'h0 || out_count !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_emit_async: got v=%b fc=%0d d=%h c=%0d, want v=0 fc=0 d=0 c=0",
               out_valid, frame_count, out_data, out_count);
    end
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (atom_ready !== 1'b1) begin n_fail++; $display("FAIL rst_emit_ready: got %b, want 1", atom_ready); end
    out_ready = 1'b1;
    sb.push_back('{30'h00000003, 4'd1});
    send_atom(2'b11);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    wait_valid(ok);
    pop_exp();
    n_checks++;
    if (!ok || out_data !== exp_f.d || out_count !== exp_f.c) begin
      n_fail++;
      $display("FAIL rst_emit_next: got ok=%b d=%h c=%0d, want ok=1 d=%h c=%0d",
               ok, out_data, out_count, exp_f.d, exp_f.c);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || atom_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL empty_flush[%0d]: got v=%b rdy=%b, want v=0 rdy=1", i, out_valid, atom_ready);
      end
    end
    test_ending = 1'b1; @(posedge clk); #1 test_ending = 1'b0;
    @(negedge clk);
    n_checks++;
    if (test_has_ended !== 1'b1 || out_valid !== 1'b0 || atom_ready !== 1'b0 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL empty_ending: got end=%b v=%b rdy=%b fc=%0d, want end=1 v=0 rdy=0 fc=0",
               test_has_ended, out_valid, atom_ready, frame_count);
    end
  endtask

  task automatic test_ending_partial();
    logic [1:0]  vals [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [29:0] acc = '0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) acc |= 30'(vals[i]) << (2 * i);
    sb.push_back('{acc, 4'd5});
    for (int i = 0; i < 5; i++) send_atom(vals[i]);
    test_ending = 1'b1; @(posedge clk); #1 test_ending = 1'b0;
    @(negedge clk);
    pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_f.d || out_count !== exp_f.c) begin
      n_fail++;
      $display("FAIL ending_frame: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
               out_valid, out_data, out_count, exp_f.d, exp_f.c);
    end
    atom_valid = 1'b1; atom_data = 2'b11;
    for (int i = 0; i < 5; i++) begin
      flush = i[0];
      @(negedge clk);
      n_checks++;
      if (test_has_ended !== 1'b1 || atom_ready !== 1'b0 || out_valid !== 1'b0 || frame_count !== 16'd1) begin
        n_fail++;
        $display("FAIL ending_done[%0d]: got end=%b rdy=%b v=%b fc=%0d, want end=1 rdy=0 v=0 fc=1",
                 i, test_has_ended, atom_ready, out_valid, frame_count);
      end
    end
    atom_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_ending_in_emit();
    do_reset();
    out_ready = 1'b0;
    send_atom(2'b10);
    send_atom(2'b11);
    sb.push_back('{30'h0000000E, 4'd2});
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    test_ending = 1'b1;
    @(posedge clk); #1 test_ending = 1'b0;
    @(negedge clk);
    pop_exp();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_f.d || out_count !== exp_f.c || test_has_ended !== 1'b0) begin
      n_fail++;
      $display("FAIL emit_ending_hold: got v=%b d=%h c=%0d end=%b, want v=1 d=%h c=%0d end=0",
               out_valid, out_data, out_count, test_has_ended, exp_f.d, exp_f.c);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (test_has_ended !== 1'b1 || out_valid !== 1'b0 || frame_count !== 16'd1 || atom_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL emit_ending_done: got end=%b v=%b fc=%0d rdy=%b, want end=1 v=0 fc=1 rdy=0",
               test_has_ended, out_valid, frame_count, atom_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_flush_hold();
    test_flush_with_atom();
    test_reset_mid_emit();
    test_zero_count();
    test_ending_partial();
    test_ending_in_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
